// File: rtl/mine_board.sv
// Minesweeper game-state engine: LFSR mine placement, per-cell neighbour counts,
// reveal/flag handling at the cursor, and a registered read port for the renderer.
//
// state | meaning
// IDLE  | after reset, no board present
// PLACE | one LFSR candidate per cycle until MINES mines are placed
// COUNT | one cell's neighbour count computed per cycle
// PLAY  | reveal/flag pulses accepted at the cursor
// LOST  | a mine was revealed; every mine is shown
// WON   | every safe cell has been revealed
module mine_board #(
    parameter int COLS  = 20,
    parameter int ROWS  = 15,
    parameter int MINES = 40
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       start,
    input  logic [7:0] seed,
    input  logic [4:0] choose_x,
    input  logic [4:0] choose_y,
    input  logic       reveal,
    input  logic       flag,
    input  logic [4:0] rd_x,
    input  logic [4:0] rd_y,
    output logic [3:0] rd_cell,
    output logic       busy,
    output logic       lost,
    output logic       won,
    output logic [6:0] mines_left
);
    localparam int         NCELL     = COLS * ROWS;
    localparam logic [8:0] NCELL9    = 9'(NCELL);
    localparam logic [8:0] LAST_CELL = 9'(NCELL - 1);
    localparam logic [8:0] MINES9    = 9'(MINES);
    localparam logic [8:0] LAST_MINE = 9'(MINES - 1);
    localparam logic [8:0] LAST_SAFE = 9'(NCELL - MINES - 1);
    localparam logic [4:0] COLS5     = 5'(COLS);
    localparam logic [4:0] ROWS5     = 5'(ROWS);
    localparam logic [4:0] LAST_COL  = 5'(COLS - 1);

    typedef enum logic [2:0] {S_IDLE, S_PLACE, S_COUNT, S_PLAY, S_LOST, S_WON} state_t;

    state_t           state;
    logic [NCELL-1:0] mine;
    logic [NCELL-1:0] revealed;
    logic [NCELL-1:0] flagged;
    logic [3:0]       cnt [NCELL];
    logic [15:0]      lfsr;
    logic [9:0]       safe_idx;
    logic [8:0]       placed;
    logic [8:0]       cidx;
    logic [4:0]       cx;
    logic [4:0]       cy;
    logic [8:0]       safe_cnt;
    logic [8:0]       flag_cnt;

    logic [9:0] cur_idx;
    logic [8:0] cur_cell;
    logic       cur_ok;
    logic [8:0] cand;
    logic       cand_ok;
    logic       lfsr_fb;
    logic [3:0] nbr;
    logic [8:0] rd_idx;
    logic       rd_ok;
    logic [3:0] rd_next;

    // cursor index kept 10 bits wide so an out-of-range cursor cannot alias a real cell
    assign cur_idx  = 10'(choose_y) * 10'(COLS) + 10'(choose_x);
    assign cur_cell = cur_idx[8:0];
    assign cur_ok   = (choose_x < COLS5) && (choose_y < ROWS5);
    assign cand     = lfsr[8:0];
    assign lfsr_fb  = lfsr[15] ^ lfsr[13] ^ lfsr[12] ^ lfsr[10];
    assign rd_idx   = 9'(10'(rd_y) * 10'(COLS) + 10'(rd_x));
    assign rd_ok    = (rd_x < COLS5) && (rd_y < ROWS5);

    assign mines_left = (flag_cnt >= MINES9) ? 7'd0 : 7'(MINES9 - flag_cnt);

    always_comb begin
        cand_ok = 1'b0;
        if (cand < NCELL9)
            cand_ok = !mine[cand] && ({1'b0, cand} != safe_idx);
    end

    always_comb begin
        nbr = 4'd0;
        for (int dy = -1; dy <= 1; dy++) begin
            for (int dx = -1; dx <= 1; dx++) begin
                if ((dx != 0 || dy != 0) &&
                    int'(cx) + dx >= 0 && int'(cx) + dx < COLS &&
                    int'(cy) + dy >= 0 && int'(cy) + dy < ROWS)
                    nbr = nbr + 4'(mine[9'((int'(cy) + dy) * COLS + int'(cx) + dx)]);
            end
        end
    end

    always_comb begin
        rd_next = 4'd9;
        if (!rd_ok)
            rd_next = 4'd15;
        else if (state == S_IDLE || state == S_PLACE || state == S_COUNT)
            rd_next = 4'd9;
        else if (mine[rd_idx] && (revealed[rd_idx] || state == S_LOST))
            rd_next = 4'd11;
        else if (revealed[rd_idx])
            rd_next = cnt[rd_idx];
        else if (flagged[rd_idx])
            rd_next = 4'd10;
    end

    always_ff @(posedge clk) begin
        if (rst)
            rd_cell <= 4'd9;
        else
            rd_cell <= rd_next;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state    <= S_IDLE;
            busy     <= 1'b0;
            lost     <= 1'b0;
            won      <= 1'b0;
            mine     <= '0;
            revealed <= '0;
            flagged  <= '0;
            for (int i = 0; i < NCELL; i++) cnt[i] <= 4'd0;
            lfsr     <= 16'h0001;
            safe_idx <= '0;
            placed   <= '0;
            cidx     <= '0;
            cx       <= '0;
            cy       <= '0;
            safe_cnt <= '0;
            flag_cnt <= '0;
        end else if (start) begin
            state    <= S_PLACE;
            busy     <= 1'b1;
            lost     <= 1'b0;
            won      <= 1'b0;
            mine     <= '0;
            revealed <= '0;
            flagged  <= '0;
            for (int i = 0; i < NCELL; i++) cnt[i] <= 4'd0;
            lfsr     <= {seed, ~seed};
            safe_idx <= cur_idx;
            placed   <= '0;
            safe_cnt <= '0;
            flag_cnt <= '0;
        end else begin
            case (state)
                S_PLACE: begin
                    lfsr <= {lfsr[14:0], lfsr_fb};
                    if (cand_ok) begin
                        mine[cand] <= 1'b1;
                        placed     <= placed + 9'd1;
                        if (placed == LAST_MINE) begin
                            state <= S_COUNT;
                            cidx  <= '0;
                            cx    <= '0;
                            cy    <= '0;
                        end
                    end
                end
                S_COUNT: begin
                    cnt[cidx] <= nbr;
                    if (cidx == LAST_CELL) begin
                        state <= S_PLAY;
                        busy  <= 1'b0;
                    end else begin
                        cidx <= cidx + 9'd1;
                        if (cx == LAST_COL) begin
                            cx <= '0;
                            cy <= cy + 5'd1;
                        end else begin
                            cx <= cx + 5'd1;
                        end
                    end
                end
                S_PLAY: begin
                    // reveal takes precedence; a simultaneous flag is dropped
                    if (cur_ok && reveal) begin
                        if (!flagged[cur_cell] && !revealed[cur_cell]) begin
                            revealed[cur_cell] <= 1'b1;
                            if (mine[cur_cell]) begin
                                state <= S_LOST;
                                lost  <= 1'b1;
                            end else begin
                                safe_cnt <= safe_cnt + 9'd1;
                                if (safe_cnt == LAST_SAFE) begin
                                    state <= S_WON;
                                    won   <= 1'b1;
                                end
                            end
                        end
                    end else if (cur_ok && flag && !revealed[cur_cell]) begin
                        flagged[cur_cell] <= !flagged[cur_cell];
                        flag_cnt <= flagged[cur_cell] ? flag_cnt - 9'd1 : flag_cnt + 9'd1;
                    end
                end
                default: ;
            endcase
        end
    end
endmodule

// File: tb/tb_mine_board.sv
// Bench for mine_board: a board model derived from the game rules predicts
// placement time, neighbour counts, display codes and win/loss for random play.
module tb_mine_board;
    localparam int COLS  = 20;
    localparam int ROWS  = 15;
    localparam int NCELL = COLS * ROWS;
    localparam int PH_IDLE = 0, PH_BUSY = 1, PH_PLAY = 2, PH_LOST = 3, PH_WON = 4;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       start = 1'b0, reveal = 1'b0, flag = 1'b0, sel_b = 1'b0;
    logic [7:0] seed = '0;
    logic [4:0] choose_x = '0, choose_y = '0, rd_x = '0, rd_y = '0;
    logic [3:0] rd_cell_a, rd_cell_b, rd_cell;
    logic       busy_a, busy_b, lost_a, lost_b, won_a, won_b;
    logic       busy, lost, won;
    logic [6:0] ml_a, ml_b, mines_left;

    always #5 clk = ~clk;

    assign rd_cell    = sel_b ? rd_cell_b : rd_cell_a;
    assign busy       = sel_b ? busy_b : busy_a;
    assign lost       = sel_b ? lost_b : lost_a;
    assign won        = sel_b ? won_b : won_a;
    assign mines_left = sel_b ? ml_b : ml_a;

    mine_board #(.COLS(20), .ROWS(15), .MINES(40)) u_a (
        .clk(clk), .rst(rst), .start(start && !sel_b), .seed(seed),
        .choose_x(choose_x), .choose_y(choose_y),
        .reveal(reveal && !sel_b), .flag(flag && !sel_b),
        .rd_x(rd_x), .rd_y(rd_y), .rd_cell(rd_cell_a),
        .busy(busy_a), .lost(lost_a), .won(won_a), .mines_left(ml_a));

    mine_board #(.COLS(20), .ROWS(15), .MINES(1)) u_b (
        .clk(clk), .rst(rst), .start(start && sel_b), .seed(seed),
        .choose_x(choose_x), .choose_y(choose_y),
        .reveal(reveal && sel_b), .flag(flag && sel_b),
        .rd_x(rd_x), .rd_y(rd_y), .rd_cell(rd_cell_b),
        .busy(busy_b), .lost(lost_b), .won(won_b), .mines_left(ml_b));

    int m_mines = 40;
    bit m_mine [NCELL];
    bit m_rev  [NCELL];
    bit m_flg  [NCELL];
    int m_flags, m_safe, m_phase;
    int n_checks = 0;
    int n_fail   = 0;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0d, expected %0d", tag, obs, exp);
        end
    endtask

    function automatic void model_clear(input int phase);
        for (int i = 0; i < NCELL; i++) begin
            m_mine[i] = 0;
            m_rev[i]  = 0;
            m_flg[i]  = 0;
        end
        m_flags = 0;
        m_safe  = 0;
        m_phase = phase;
    endfunction

    // returns the number of candidate draws needed to place every mine
    function automatic int model_start(input logic [7:0] sd, input int safe);
        logic [15:0] l;
        int placed = 0;
        int draws = 0;
        int c;
        model_clear(PH_BUSY);
        l = {sd, ~sd};
        while (placed < m_mines && draws < 100000) begin
            c = int'(l[8:0]);
            draws++;
            if (c < NCELL && !m_mine[c] && c != safe) begin
                m_mine[c] = 1;
                placed++;
            end
            l = {l[14:0], l[15] ^ l[13] ^ l[12] ^ l[10]};
        end
        return draws;
    endfunction

    function automatic int exp_count(input int idx);
        int x = idx % COLS;
        int y = idx / COLS;
        int n = 0;
        for (int yy = y - 1; yy <= y + 1; yy++)
            for (int xx = x - 1; xx <= x + 1; xx++)
                if (!(xx == x && yy == y) && xx >= 0 && xx < COLS && yy >= 0 && yy < ROWS
                    && m_mine[yy * COLS + xx])
                    n++;
        return n;
    endfunction

    function automatic int exp_code(input int x, input int y);
        int i;
        if (x >= COLS || y >= ROWS) return 15;
        i = y * COLS + x;
        if (m_phase == PH_IDLE || m_phase == PH_BUSY) return 9;
        if (m_mine[i] && (m_rev[i] || m_phase == PH_LOST)) return 11;
        if (m_rev[i]) return exp_count(i);
        if (m_flg[i]) return 10;
        return 9;
    endfunction

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic status(input string tag);
        chk({tag, "_lost"}, 32'(lost), 32'(m_phase == PH_LOST));
        chk({tag, "_won"}, 32'(won), 32'(m_phase == PH_WON));
        chk({tag, "_mines_left"}, 32'(mines_left),
            (m_flags >= m_mines) ? 0 : m_mines - m_flags);
    endtask

    task automatic pulse(input int x, input int y, input bit rv, input bit fl);
        int i;
        choose_x = 5'(x);
        choose_y = 5'(y);
        reveal = rv;
        flag = fl;
        tick();
        reveal = 1'b0;
        flag = 1'b0;
        if (m_phase == PH_PLAY && x < COLS && y < ROWS) begin
            i = y * COLS + x;
            if (rv) begin
                if (!m_flg[i] && !m_rev[i]) begin
                    m_rev[i] = 1;
                    if (m_mine[i]) m_phase = PH_LOST;
                    else begin
                        m_safe++;
                        if (m_safe == NCELL - m_mines) m_phase = PH_WON;
                    end
                end
            end else if (fl && !m_rev[i]) begin
                m_flg[i] = !m_flg[i];
                m_flags += m_flg[i] ? 1 : -1;
            end
        end
    endtask

    task automatic read_cell(input int x, input int y, input string tag);
        rd_x = 5'(x);
        rd_y = 5'(y);
        tick();
        chk(tag, 32'(rd_cell), exp_code(x, y));
    endtask

    task automatic do_start(input logic [7:0] sd, input int x, input int y, output int draws);
        seed = sd;
        choose_x = 5'(x);
        choose_y = 5'(y);
        start = 1'b1;
        tick();
        start = 1'b0;
        draws = model_start(sd, y * COLS + x);
    endtask

    task automatic wait_busy(input string tag, input int exp_len, output int n);
        n = 0;
        chk({tag, "_busy_after_start"}, 32'(busy), 1);
        while (busy && n < 20000) begin
            tick();
            n++;
        end
        chk({tag, "_busy_cycles"}, n, exp_len);
        m_phase = PH_PLAY;
    endtask

    task automatic reveal_all_safe(input string tag, input bit with_reads);
        int q[$];
        int j, t, rx, ry;
        for (int i = 0; i < NCELL; i++)
            if (!m_mine[i] && !m_rev[i]) q.push_back(i);
        for (int i = q.size() - 1; i > 0; i--) begin
            j = int'($urandom_range(0, i));
            t = q[i];
            q[i] = q[j];
            q[j] = t;
        end
        foreach (q[k]) begin
            if ($urandom_range(0, 7) == 0) begin
                rx = int'($urandom_range(0, COLS - 1));
                ry = int'($urandom_range(0, ROWS - 1));
                pulse(rx, ry, 0, 1);
                status({tag, "_flag_on"});
                pulse(rx, ry, 0, 1);
                status({tag, "_flag_off"});
            end
            pulse(q[k] % COLS, q[k] / COLS, 1, 0);
            status({tag, "_reveal"});
            if (with_reads) read_cell(q[k] % COLS, q[k] / COLS, {tag, "_reveal_code"});
        end
    endtask

    task automatic reveal_a_mine(input string tag);
        int s, i;
        bit found = 0;
        s = int'($urandom_range(0, NCELL - 1));
        for (int k = 0; k < NCELL && !found; k++) begin
            i = (s + k) % NCELL;
            if (m_mine[i]) found = 1;
        end
        pulse(i % COLS, i / COLS, 1, 0);
        status({tag, "_mine_hit"});
        read_cell(i % COLS, i / COLS, {tag, "_mine_code"});
    endtask

    task automatic scan_all(input string tag, output int n11);
        n11 = 0;
        for (int i = 0; i < NCELL; i++) begin
            read_cell(i % COLS, i / COLS, tag);
            if (rd_cell == 4'd11) n11++;
        end
    endtask

    initial begin
        int p, n, n11, sd;
        int bx, by;

        model_clear(PH_IDLE);
        rst = 1'b1;
        repeat (3) tick();
        chk("reset_busy", 32'(busy), 0);
        chk("reset_rd_cell", 32'(rd_cell), 9);
        status("reset");
        rst = 1'b0;
        read_cell(0, 0, "idle_rd");
        read_cell(25, 3, "idle_rd_oor");

        // game 1: seed 1C, safe cursor (7,7), reveal every safe cell
        do_start(8'h1C, 7, 7, p);
        wait_busy("g1", p + NCELL, n);
        chk("g1_busy_at_least_340", 32'(n >= 340), 1);
        for (int k = 0; k < 12; k++)
            read_cell(int'($urandom_range(0, 31)), int'($urandom_range(0, 31)), "g1_hidden_rd");
        reveal_all_safe("g1", 1);
        reveal_a_mine("g1_after_win");

        // game 2: same board, hit a mine and inspect the whole board
        do_start(8'h1C, 7, 7, p);
        wait_busy("g2", p + NCELL, n);
        reveal_a_mine("g2");
        scan_all("g2_lost_scan", n11);
        chk("g2_mine_total", n11, 40);
        read_cell(7, 7, "g2_cursor_cell");
        chk("g2_cursor_not_mine", 32'(rd_cell == 4'd11), 0);
        pulse(0, 0, 0, 1);
        status("g2_flag_in_lost");

        // game 3: flag handling, saturation and cursor range
        sd = int'($urandom_range(0, 255));
        do_start(8'(sd), 4, 4, p);
        wait_busy("g3", p + NCELL, n);
        pulse(3, 3, 0, 1);
        status("g3_flag33");
        read_cell(3, 3, "g3_flag33_code");
        pulse(3, 3, 1, 0);
        status("g3_reveal_flagged");
        read_cell(3, 3, "g3_reveal_flagged_code");
        pulse(3, 3, 0, 1);
        status("g3_unflag33");
        read_cell(3, 3, "g3_unflag33_code");
        pulse(4, 4, 1, 1);
        status("g3_reveal_and_flag");
        read_cell(4, 4, "g3_reveal_and_flag_code");
        for (int i = 0; i < 41; i++) begin
            pulse(i % COLS, i / COLS, 0, 1);
            status("g3_flag_many");
        end
        pulse(0, 0, 0, 1);
        status("g3_unflag_at_40");
        pulse(1, 0, 0, 1);
        status("g3_unflag_at_39");
        pulse(19, 14, 0, 1);
        status("g3_flag_corner");
        read_cell(19, 14, "g3_corner_code");
        pulse(20, 0, 1, 1);
        status("g3_oor_both");
        pulse(20, 0, 0, 1);
        status("g3_oor_flag");
        read_cell(20, 0, "g3_oor_code");
        for (int k = 0; k < 40; k++) begin
            bx = int'($urandom_range(0, 21));
            by = int'($urandom_range(0, 16));
            pulse(bx, by, ($urandom_range(0, 3) == 0), $urandom_range(0, 1) == 1);
            status("g3_random");
            read_cell(bx, by, "g3_random_code");
        end

        // game 4: single-mine board
        sel_b = 1'b1;
        m_mines = 1;
        sd = int'($urandom_range(0, 255));
        bx = int'($urandom_range(0, COLS - 1));
        by = int'($urandom_range(0, ROWS - 1));
        do_start(8'(sd), bx, by, p);
        wait_busy("g4", p + NCELL, n);
        reveal_all_safe("g4", 0);
        do_start(8'(sd), bx, by, p);
        wait_busy("g4b", p + NCELL, n);
        reveal_a_mine("g4b");
        sel_b = 1'b0;
        m_mines = 40;

        // game 5: reset mid-PLACE, then restart mid-PLACE with seed A3
        do_start(8'($urandom_range(0, 255)), 7, 7, p);
        repeat (4) tick();
        chk("g5_in_place", 32'(busy), 1);
        rst = 1'b1;
        tick();
        rst = 1'b0;
        model_clear(PH_IDLE);
        chk("g5_rst_busy", 32'(busy), 0);
        status("g5_rst");
        scan_all("g5_idle_scan", n11);
        do_start(8'($urandom_range(0, 255)), 7, 7, p);
        repeat (5) tick();
        do_start(8'hA3, 7, 7, p);
        wait_busy("g5", p + NCELL, n);
        reveal_a_mine("g5");
        scan_all("g5_lost_scan", n11);
        chk("g5_mine_total", n11, 40);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end
endmodule
